// File: rtl/hyperbus_sched_pkg.sv
// Shared types for the HyperBus transaction scheduler: FSM state encoding
// and the registered chunk descriptor presented to the PHY.
package hyperbus_sched_pkg;

  localparam int unsigned HB_NR_CS      = 2;
  localparam int unsigned HB_ADDR_WIDTH = 32;
  localparam int unsigned HB_LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    RECOVER   = 3'd4
  } sched_state_e;

  // Chunk descriptor; widths follow the default scheduler geometry above.
  typedef struct packed {
    logic [HB_ADDR_WIDTH-1:0] addr;
    logic [HB_LEN_WIDTH-1:0]  len;
    logic                     write;
    logic [HB_NR_CS-1:0]      cs;
    logic                     last;
  } chunk_t;

endpackage

// File: rtl/hyperbus_cs_decoder.sv
// Combinational address-map lookup: word address -> one-hot chip select,
// hit flag and the inclusive end address of the matching region.
// Region i occupies map bits [64i+31:64i] (start) and [64i+63:64i+32] (end).
module hyperbus_cs_decoder #(
  parameter int unsigned NR_CS      = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [64*NR_CS-1:0]   i_map,
  output logic [NR_CS-1:0]      o_cs,
  output logic                  o_hit,
  output logic [ADDR_WIDTH-1:0] o_region_end
);

  // Scan from the highest region down so the lowest matching index wins.
  always_comb begin
    o_cs         = '0;
    o_hit        = 1'b0;
    o_region_end = '0;
    for (int i = NR_CS - 1; i >= 0; i--) begin
      if ((i_addr >= i_map[64*i +: ADDR_WIDTH]) &&
          (i_addr <= i_map[64*i + 32 +: ADDR_WIDTH])) begin
        o_cs         = '0;
        o_cs[i]      = 1'b1;
        o_hit        = 1'b1;
        o_region_end = i_map[64*i + 32 +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/hyperbus_txn_scheduler.sv
// HyperBus transaction scheduler: accepts linear word requests, splits them
// into PHY chunks bounded by the CS-low word budget and the CS region end,
// and inserts recovery cycles between chunks.
// Optional feature: define HYPERBUS_SCHED_STATS_EN to add stat_splits_o, a
// saturating count of chunks handed to the PHY that were not the last of
// their request.
//
// state     | meaning
// IDLE      | ready for a new request
// DECODE    | map lookup and chunk sizing for the current address
// ISSUE     | chunk presented to the PHY, waiting for tx_ready_i
// WAIT_DONE | PHY owns the bus, waiting for done_i
// RECOVER   | recovery count-down before the next chunk or IDLE
module hyperbus_txn_scheduler
  import hyperbus_sched_pkg::*;
#(
  parameter int unsigned NR_CS              = HB_NR_CS,
  parameter int unsigned ADDR_WIDTH         = HB_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH          = HB_LEN_WIDTH,
  parameter int unsigned ADDR_MAPPING_WIDTH = 64 * NR_CS
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [31:0]                   cfg_t_cs_max_i,
  input  logic [31:0]                   cfg_t_rwr_i,
  input  logic [ADDR_MAPPING_WIDTH-1:0] cfg_addr_mapping_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [LEN_WIDTH-1:0]          req_len_i,
  input  logic                          req_write_i,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [ADDR_WIDTH-1:0]         tx_addr_o,
  output logic [LEN_WIDTH-1:0]          tx_len_o,
  output logic                          tx_write_o,
  output logic [NR_CS-1:0]              tx_cs_o,
  output logic                          tx_last_o,
  input  logic                          done_i,
  output logic                          err_o,
  output logic                          busy_o
`ifdef HYPERBUS_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_splits_o
`endif
);

  sched_state_e                  r_state;
  sched_state_e                  w_next_state;

  logic [ADDR_WIDTH-1:0]         r_addr;
  logic [LEN_WIDTH-1:0]          r_rem;
  logic                          r_write;
  logic [LEN_WIDTH-1:0]          r_budget;
  logic [31:0]                   r_rwr;
  logic [ADDR_MAPPING_WIDTH-1:0] r_map;
  logic [31:0]                   r_cnt;
  chunk_t                        r_chunk;

  logic [NR_CS-1:0]              w_cs;
  logic                          w_hit;
  logic [ADDR_WIDTH-1:0]         w_region_end;
  logic [ADDR_WIDTH:0]           w_room;
  logic [LEN_WIDTH-1:0]          w_lim;
  logic [LEN_WIDTH-1:0]          w_chunk_len;
  logic [LEN_WIDTH-1:0]          w_cs_max_lo;
  logic                          w_last;
  logic                          w_err;
  logic                          w_tx_hs;
  logic                          w_recover_tc;
  logic                          w_unused_cs_max;

  // Only the low LEN_WIDTH bits of the CS-low budget are meaningful.
  assign w_cs_max_lo     = cfg_t_cs_max_i[LEN_WIDTH-1:0];
  assign w_unused_cs_max = ^cfg_t_cs_max_i[31:LEN_WIDTH];

  hyperbus_cs_decoder #(
    .NR_CS      (NR_CS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cs_decoder (
    .i_addr       (r_addr),
    .i_map        (r_map),
    .o_cs         (w_cs),
    .o_hit        (w_hit),
    .o_region_end (w_region_end)
  );

  // Chunk sizing: min(remaining, budget, words left in the CS region).
  always_comb begin
    w_room      = {1'b0, w_region_end} - {1'b0, r_addr} + (ADDR_WIDTH + 1)'(1);
    w_lim       = (r_rem < r_budget) ? r_rem : r_budget;
    w_chunk_len = (w_room < (ADDR_WIDTH + 1)'(w_lim)) ? w_room[LEN_WIDTH-1:0] : w_lim;
    w_last      = (w_chunk_len == r_rem);
    w_err       = !w_hit || (r_rem == '0);
  end

  assign w_tx_hs      = (r_state == ISSUE) && tx_ready_i;
  assign w_recover_tc = (r_cnt <= 32'd1);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    w_next_state = r_state;
    req_ready_o  = 1'b0;
    tx_valid_o   = 1'b0;
    err_o        = 1'b0;
    busy_o       = 1'b1;
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) w_next_state = DECODE;
      end
      DECODE: begin
        err_o        = w_err;
        w_next_state = w_err ? IDLE : ISSUE;
      end
      ISSUE: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) w_next_state = RECOVER;
      end
      RECOVER: begin
        if (w_recover_tc) w_next_state = (r_rem != '0) ? DECODE : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request context: latched on accept, advanced on each chunk handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_rem    <= '0;
      r_write  <= 1'b0;
      r_budget <= '0;
      r_rwr    <= '0;
      r_map    <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid_i) begin
        r_addr   <= req_addr_i;
        r_rem    <= req_len_i;
        r_write  <= req_write_i;
        r_budget <= (w_cs_max_lo == '0) ? LEN_WIDTH'(1) : w_cs_max_lo;
        r_rwr    <= cfg_t_rwr_i;
        r_map    <= cfg_addr_mapping_i;
      end else if ((r_state == DECODE) && w_err) begin
        r_rem <= '0;
      end else if (w_tx_hs) begin
        r_addr <= r_addr + ADDR_WIDTH'(r_chunk.len);
        r_rem  <= r_rem - r_chunk.len;
      end
    end
  end

  // Registered chunk descriptor, captured in DECODE and held through ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_chunk <= '0;
    end else if ((r_state == DECODE) && !w_err) begin
      r_chunk <= '{addr: r_addr, len: w_chunk_len, write: r_write, cs: w_cs, last: w_last};
    end
  end

  // Recovery down-counter; a load of 0 or 1 still spends one RECOVER cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if ((r_state == WAIT_DONE) && done_i) begin
      r_cnt <= r_rwr;
    end else if ((r_state == RECOVER) && !w_recover_tc) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  assign tx_addr_o  = r_chunk.addr;
  assign tx_len_o   = r_chunk.len;
  assign tx_write_o = r_chunk.write;
  assign tx_cs_o    = r_chunk.cs;
  assign tx_last_o  = r_chunk.last;

`ifdef HYPERBUS_SCHED_STATS_EN
  logic [31:0] r_stat_splits;

  // Count non-final chunks accepted by the PHY, saturating at all ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_splits <= '0;
    end else if (w_tx_hs && !r_chunk.last && (r_stat_splits != 32'hFFFF_FFFF)) begin
      r_stat_splits <= r_stat_splits + 32'd1;
    end
  end

  assign stat_splits_o = r_stat_splits;
`endif

endmodule

// File: tb/tb_hyperbus_txn_scheduler.sv
// Directed bench for hyperbus_txn_scheduler: a vector table of requests with
// hand-computed chunk sequences, plus hand-written stall and reset sequences.
module tb_hyperbus_txn_scheduler;

  localparam int NR_CS = 2;
  localparam int AW    = 32;
  localparam int LW    = 16;
  localparam int MW    = 64 * NR_CS;
  localparam int NV    = 8;
  localparam int NC    = 12;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   cfg_t_cs_max_i = 32'd665;
  logic [31:0]   cfg_t_rwr_i = 32'd6;
  logic [MW-1:0] cfg_addr_mapping_i = {32'h007F_FFFF, 32'h0040_0000, 32'h003F_FFFF, 32'h0000_0000};
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic          req_write_i = 1'b0;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b1;
  logic [AW-1:0] tx_addr_o;
  logic [LW-1:0] tx_len_o;
  logic          tx_write_o;
  logic [NR_CS-1:0] tx_cs_o;
  logic          tx_last_o;
  logic          done_i = 1'b0;
  logic          err_o;
  logic          busy_o;
`ifdef HYPERBUS_SCHED_STATS_EN
  logic [31:0]   stat_splits_o;
`endif

  hyperbus_txn_scheduler dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .cfg_t_cs_max_i     (cfg_t_cs_max_i),
    .cfg_t_rwr_i        (cfg_t_rwr_i),
    .cfg_addr_mapping_i (cfg_addr_mapping_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_len_i          (req_len_i),
    .req_write_i        (req_write_i),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i),
    .tx_addr_o          (tx_addr_o),
    .tx_len_o           (tx_len_o),
    .tx_write_o         (tx_write_o),
    .tx_cs_o            (tx_cs_o),
    .tx_last_o          (tx_last_o),
    .done_i             (done_i),
    .err_o              (err_o),
    .busy_o             (busy_o)
`ifdef HYPERBUS_SCHED_STATS_EN
    ,
    .stat_splits_o      (stat_splits_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        wr;
    logic [31:0] cs_max;
    logic [31:0] rwr;
    logic        err;
    logic [3:0]  nchunk;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [1:0]  cs;
    logic        last;
  } exp_chunk_t;

  vec_t       vecs [NV];
  exp_chunk_t ech  [NC];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_splits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_valid_o) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [15:0] l, input logic w);
    req_addr_i  = a;
    req_len_i   = l;
    req_write_i = w;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    bit          ok;
    int          ci;
    int          cnt;
    int          r_eff;
    bit          seen;
    logic [51:0] cap;

    // addr, len, wr, cs_max, rwr, err, nchunk
    vecs[0] = '{addr:32'h0000_0100, len:16'd8,  wr:1'b1, cs_max:32'd665,       rwr:32'd6, err:1'b0, nchunk:4'd1};
    vecs[1] = '{addr:32'h0000_0000, len:16'd10, wr:1'b0, cs_max:32'd4,         rwr:32'd6, err:1'b0, nchunk:4'd3};
    vecs[2] = '{addr:32'h003F_FFFE, len:16'd4,  wr:1'b1, cs_max:32'd665,       rwr:32'd6, err:1'b0, nchunk:4'd2};
    vecs[3] = '{addr:32'h0080_0000, len:16'd4,  wr:1'b0, cs_max:32'd665,       rwr:32'd6, err:1'b1, nchunk:4'd0};
    vecs[4] = '{addr:32'h0000_0200, len:16'd0,  wr:1'b1, cs_max:32'd665,       rwr:32'd6, err:1'b1, nchunk:4'd0};
    vecs[5] = '{addr:32'h0040_0010, len:16'd3,  wr:1'b0, cs_max:32'd0,         rwr:32'd0, err:1'b0, nchunk:4'd3};
    vecs[6] = '{addr:32'h007F_FFFF, len:16'd1,  wr:1'b1, cs_max:32'd665,       rwr:32'd2, err:1'b0, nchunk:4'd1};
    vecs[7] = '{addr:32'h0000_0010, len:16'd5,  wr:1'b0, cs_max:32'h0001_0003, rwr:32'd1, err:1'b0, nchunk:4'd2};

    // addr, len, cs, last
    ech[0]  = '{addr:32'h0000_0100, len:16'd8, cs:2'b01, last:1'b1};
    ech[1]  = '{addr:32'h0000_0000, len:16'd4, cs:2'b01, last:1'b0};
    ech[2]  = '{addr:32'h0000_0004, len:16'd4, cs:2'b01, last:1'b0};
    ech[3]  = '{addr:32'h0000_0008, len:16'd2, cs:2'b01, last:1'b1};
    ech[4]  = '{addr:32'h003F_FFFE, len:16'd2, cs:2'b01, last:1'b0};
    ech[5]  = '{addr:32'h0040_0000, len:16'd2, cs:2'b10, last:1'b1};
    ech[6]  = '{addr:32'h0040_0010, len:16'd1, cs:2'b10, last:1'b0};
    ech[7]  = '{addr:32'h0040_0011, len:16'd1, cs:2'b10, last:1'b0};
    ech[8]  = '{addr:32'h0040_0012, len:16'd1, cs:2'b10, last:1'b1};
    ech[9]  = '{addr:32'h007F_FFFF, len:16'd1, cs:2'b10, last:1'b1};
    ech[10] = '{addr:32'h0000_0010, len:16'd3, cs:2'b01, last:1'b0};
    ech[11] = '{addr:32'h0000_0013, len:16'd2, cs:2'b01, last:1'b1};

    repeat (3) tick();
    check("reset_outputs",
          64'({req_ready_o, tx_valid_o, tx_addr_o, tx_len_o, tx_cs_o, tx_write_o, tx_last_o, err_o, busy_o}),
          64'({1'b1, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}));
    rst_ni = 1'b1;
    tick();

    ci = 0;
    for (int v = 0; v < NV; v++) begin
      cfg_t_cs_max_i = vecs[v].cs_max;
      cfg_t_rwr_i    = vecs[v].rwr;
      r_eff          = (vecs[v].rwr == 32'd0) ? 1 : int'(vecs[v].rwr);
      check("idle_ready", 64'(req_ready_o), 64'(1));
      send_req(vecs[v].addr, vecs[v].len, vecs[v].wr);
      if (vecs[v].err) begin
        check("err_pulse", 64'({err_o, tx_valid_o, req_ready_o}), 64'(3'b100));
        tick();
        check("err_to_idle", 64'({err_o, tx_valid_o, req_ready_o, busy_o}), 64'(4'b0010));
      end else begin
        for (int k = 0; k < int'(vecs[v].nchunk); k++) begin
          wait_tx(ok);
          if (!ok) begin
            check("tx_valid_timeout", 64'(0), 64'(1));
            break;
          end
          check("chunk", 64'({tx_addr_o, tx_len_o, tx_cs_o, tx_write_o, tx_last_o}),
                64'({ech[ci].addr, ech[ci].len, ech[ci].cs, vecs[v].wr, ech[ci].last}));
          ci++;
          tick();
          tick();
          done_i = 1'b1;
          tick();
          done_i = 1'b0;
          cnt = 1;
          if (k == int'(vecs[v].nchunk) - 1) begin
            while (!req_ready_o && cnt < 100) begin tick(); cnt++; end
            check("recover_to_idle", 64'(cnt), 64'(r_eff + 1));
          end else begin
            while (!tx_valid_o && cnt < 100) begin tick(); cnt++; end
            check("recover_to_next", 64'(cnt), 64'(r_eff + 2));
          end
        end
        exp_splits += int'(vecs[v].nchunk) - 1;
      end
`ifdef HYPERBUS_SCHED_STATS_EN
      check("stat_splits", 64'(stat_splits_o), 64'(exp_splits));
`endif
      tick();
    end

    // Stall in ISSUE with a mid-request config change, then reset in WAIT_DONE.
    cfg_t_cs_max_i = 32'd665;
    cfg_t_rwr_i    = 32'd6;
    tx_ready_i     = 1'b0;
    send_req(32'h0000_0100, 16'd8, 1'b1);
    cfg_t_cs_max_i = 32'd1;
    cfg_t_rwr_i    = 32'd0;
    wait_tx(ok);
    check("stall_tx_seen", 64'(ok), 64'(1));
    cap = {tx_addr_o, tx_len_o, tx_cs_o, tx_write_o, tx_last_o};
    check("stall_chunk", 64'(cap), 64'({32'h0000_0100, 16'd8, 2'b01, 1'b1, 1'b1}));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", 64'({tx_valid_o, tx_addr_o, tx_len_o, tx_cs_o, tx_write_o, tx_last_o}),
            64'({1'b1, cap}));
    end
    tx_ready_i = 1'b1;
    tick();
    check("wait_done_busy", 64'({tx_valid_o, busy_o}), 64'(2'b01));
    tick();
    rst_ni = 1'b0;
    #1;
    check("midop_reset",
          64'({req_ready_o, tx_valid_o, tx_addr_o, tx_len_o, tx_cs_o, tx_write_o, tx_last_o, err_o, busy_o}),
          64'({1'b1, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}));
`ifdef HYPERBUS_SCHED_STATS_EN
    check("stat_reset", 64'(stat_splits_o), 64'(0));
`endif
    tick();
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      done_i = (i == 3);
      tick();
      if (tx_valid_o || busy_o) seen = 1'b1;
    end
    done_i = 1'b0;
    check("no_replay", 64'({seen, req_ready_o}), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
